instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the instruction queue depth (power of two, 2..16).
REQ-002 Parameter CNT_W, default 16, SHALL set the retired-instruction counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 instr_valid  input  1  SHALL flag that instr carries an instruction offered by the requester.
REQ-006 instr_ready  output  1  SHALL flag that the queue can accept an instruction this cycle.
REQ-007 instr  input  32  SHALL carry the MIPS-format instruction word.
REQ-008 dp_instruction  output  32  SHALL carry the instruction word driven into the datapath.
REQ-009 dp_wr_en  output  1  SHALL be the register-file write enable gate into the datapath.
REQ-010 dp_result  input  32  SHALL carry the datapath ALU result.
REQ-011 res_valid / res_ready  output / input  1 / 1  SHALL form the result handshake.
REQ-012 res_data  output  32  SHALL carry the captured result; res_rd  output  5  SHALL carry its destination register.
REQ-013 illegal  output  1  SHALL pulse for a rejected instruction; busy  output  1  SHALL flag pending work.
REQ-014 retired  output  CNT_W  SHALL count completed result handshakes.

Function
REQ-015 Queue: FIFO of FIFO_DEPTH 32-bit entries; push when instr_valid && instr_ready; instr_ready = !full.
REQ-016 A push and a pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-017 States: IDLE, DECODE, EXECUTE, WRITE, RESP; one state per cycle except RESP, which holds until handshake.
REQ-018 IDLE: if the queue is non-empty, pop head into instr_reg and go to DECODE; else stay.
REQ-019 DECODE: legal iff opcode (bits 31:26) = 0 and funct (bits 5:0) in {0x20, 0x22, 0x24, 0x25, 0x2A}.
REQ-020 DECODE, illegal: illegal high for exactly this one cycle, instruction discarded, next state IDLE, retired unchanged.
REQ-021 DECODE, legal: next state EXECUTE.
REQ-022 dp_instruction SHALL equal instr_reg in DECODE, EXECUTE and WRITE, and 32'h0 in IDLE and RESP.
REQ-023 EXECUTE: res_data <= dp_result and res_rd <= instr_reg[15:11] at the exit edge; next state WRITE.
REQ-024 WRITE: dp_wr_en high for exactly this cycle, unless res_rd = 0, in which case it stays low; next state RESP.
REQ-025 dp_wr_en SHALL be low in every state other than WRITE.
REQ-026 RESP: res_valid high; res_data and res_rd held stable until res_valid && res_ready.
REQ-027 RESP handshake: retired increments by 1; pop next head directly to DECODE if queue non-empty, else go to IDLE.
REQ-028 retired SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-029 Latency: with empty queue in IDLE, res_valid SHALL rise 4 clock edges after the accepting edge.
REQ-030 Back-to-back: with res_ready held high and queue non-empty, results SHALL issue every 4 cycles.
REQ-031 busy = (state != IDLE) || queue non-empty.

Reset
REQ-032 reset low SHALL immediately force: state IDLE, queue empty, instr_ready 1, dp_wr_en 0, res_valid 0, illegal 0.
REQ-033 reset low SHALL also immediately clear res_data, res_rd, retired, dp_instruction and busy to 0.
REQ-034 reset asserted mid-instruction SHALL abort it with no dp_wr_en pulse; queued entries are lost.
REQ-035 Operation SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-036 Push 0x00221820 (add $3,$1,$2), dp_result=0x5, res_ready=1 -> dp_wr_en one cycle; res_valid 4 edges after accept; res_data=0x5; res_rd=3; retired=1.
REQ-037 Push 0x00220020 (add, rd=0) -> dp_wr_en never high; res_valid with res_rd=0; retired increments.
REQ-038 Push 0x8C220000 (lw) -> illegal one-cycle pulse in DECODE; no res_valid; dp_wr_en stays low; retired unchanged.
REQ-039 Hold res_ready=0, push 5 instructions -> instr_ready drops after 4 queued plus 1 in flight; res_data stable; release -> 5 results in order.
REQ-040 Preload retired to 2^CNT_W-1 via a long run, complete one more -> retired=0.
REQ-041 Assert reset during WRITE -> dp_wr_en falls without waiting for a clock edge; all outputs at reset values; next push completes normally.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: queues MIPS R-type words and steps each one
// through decode, execute, register write and a result handshake.
module instr_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [31:0]      dp_instruction,
  output logic             dp_wr_en,
  input  logic [31:0]      dp_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [4:0]       res_rd,
  output logic             illegal,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t r_state, w_next;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic [31:0]      r_instr;
  logic [31:0]      r_res_data;
  logic [4:0]       r_res_rd;
  logic [CNT_W-1:0] r_retired;

  logic w_full, w_empty, w_push, w_pop;
  logic w_legal, w_done;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = instr_valid && !w_full;
  assign w_done  = (r_state == S_RESP) && res_ready;

  // R-type with one of the supported ALU functs
  always_comb begin
    w_legal = 1'b0;
    if (r_instr[31:26] == 6'd0) begin
      case (r_instr[5:0])
        6'h20, 6'h22, 6'h24,
        6'h25, 6'h2A: w_legal = 1'b1;
        default:      w_legal = 1'b0;
      endcase
    end
  end

  // Next state and queue pop
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE:  w_next = w_legal ? S_EXECUTE : S_IDLE;
      S_EXECUTE: w_next = S_WRITE;
      S_WRITE:   w_next = S_RESP;
      S_RESP: begin
        if (res_ready) begin
          w_pop  = !w_empty;
          w_next = w_empty ? S_IDLE : S_DECODE;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Queue storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= instr;
  end

  // State, pointers, captured instruction/result and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_instr    <= '0;
      r_res_data <= '0;
      r_res_rd   <= '0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop) begin
        r_rptr  <= r_rptr + PTR_ONE;
        r_instr <= r_mem[r_rptr[AW-1:0]];
      end
      if (r_state == S_EXECUTE) begin
        r_res_data <= dp_result;
        r_res_rd   <= r_instr[15:11];
      end
      if (w_done) r_retired <= r_retired + CNT_ONE;
    end
  end

  // Outputs decode straight from state so reset clears them at once
  always_comb begin
    dp_instruction = 32'h0;
    if (r_state == S_DECODE || r_state == S_EXECUTE ||
        r_state == S_WRITE)
      dp_instruction = r_instr;
  end

  assign instr_ready = !w_full;
  assign dp_wr_en    = (r_state == S_WRITE) && (r_res_rd != 5'd0);
  assign res_valid   = (r_state == S_RESP);
  assign illegal     = (r_state == S_DECODE) && !w_legal;
  assign busy        = (r_state != S_IDLE) || !w_empty;
  assign res_data    = r_res_data;
  assign res_rd      = r_res_rd;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
// Counter width is reduced so the wrap case stays short.
module tb_instr_sequencer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          instr_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [31:0]   instr = '0;
  logic [31:0]   dp_fixed = '0;
  logic          dp_auto = 1'b0;
  logic          instr_ready, dp_wr_en, res_valid;
  logic          illegal, busy;
  logic [31:0]   dp_instruction, dp_result, res_data;
  logic [4:0]    res_rd;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;

  logic          got;
  logic [31:0]   gdata;
  logic [4:0]    grd;

  instr_sequencer #(.FIFO_DEPTH(4), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .dp_instruction (dp_instruction),
    .dp_wr_en       (dp_wr_en),
    .dp_result      (dp_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_rd         (res_rd),
    .illegal        (illegal),
    .busy           (busy),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  assign dp_result = dp_auto ? (dp_instruction ^ 32'hCAFE0000)
                             : dp_fixed;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd);
    return {6'd0, 5'd1, 5'd2, rd, 5'd0, 6'h20};
  endfunction

  task automatic run_one(input logic [31:0] w, output logic g,
                         output logic [31:0] d, output logic [4:0] r);
    g = 1'b0;
    d = '0;
    r = '0;
    instr = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid && !g) begin
        g = 1'b1;
        d = res_data;
        r = res_rd;
      end
      if (!busy) break;
    end
    chk("run_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_we", 32'(dp_wr_en), 32'd0);
    chk("rst_rv", 32'(res_valid), 32'd0);
    chk("rst_ill", 32'(illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_ret", 32'(retired), 32'd0);
    chk("rst_dpi", dp_instruction, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // add $3,$1,$2 with latency trace
    instr = 32'h00221820;
    instr_valid = 1'b1;
    dp_fixed = 32'h5;
    res_ready = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_idle_dpi", dp_instruction, 32'd0);
    tick();
    chk("t1_dec_dpi", dp_instruction, 32'h00221820);
    chk("t1_dec_ill", 32'(illegal), 32'd0);
    tick();
    chk("t1_exe_we", 32'(dp_wr_en), 32'd0);
    chk("t1_exe_dpi", dp_instruction, 32'h00221820);
    tick();
    chk("t1_wr_we", 32'(dp_wr_en), 32'd1);
    chk("t1_wr_rv", 32'(res_valid), 32'd0);
    chk("t1_wr_data", res_data, 32'h5);
    chk("t1_wr_rd", 32'(res_rd), 32'd3);
    tick();
    chk("t1_rsp_rv", 32'(res_valid), 32'd1);
    chk("t1_rsp_we", 32'(dp_wr_en), 32'd0);
    chk("t1_rsp_dpi", dp_instruction, 32'd0);
    chk("t1_rsp_data", res_data, 32'h5);
    tick();
    chk("t1_done_rv", 32'(res_valid), 32'd0);
    chk("t1_ret", 32'(retired), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // rd = 0 suppresses the write enable
    instr = 32'h00220020;
    instr_valid = 1'b1;
    dp_fixed = 32'h7;
    tick();
    instr_valid = 1'b0;
    repeat (3) tick();
    chk("t2_wr_we", 32'(dp_wr_en), 32'd0);
    tick();
    chk("t2_rv", 32'(res_valid), 32'd1);
    chk("t2_rd", 32'(res_rd), 32'd0);
    chk("t2_data", res_data, 32'h7);
    chk("t2_we", 32'(dp_wr_en), 32'd0);
    tick();
    chk("t2_ret", 32'(retired), 32'd2);

    // lw and addu are rejected
    instr = 32'h8C220000;
    instr_valid = 1'b1;
    tick();
    instr = 32'h00221821;
    tick();
    instr_valid = 1'b0;
    chk("t3_lw_ill", 32'(illegal), 32'd1);
    chk("t3_lw_we", 32'(dp_wr_en), 32'd0);
    tick();
    chk("t3_lw_pulse", 32'(illegal), 32'd0);
    tick();
    chk("t3_addu_ill", 32'(illegal), 32'd1);
    tick();
    chk("t3_addu_pulse", 32'(illegal), 32'd0);
    chk("t3_rv", 32'(res_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_ret", 32'(retired), 32'd2);

    // back-pressure: 1 in flight + 4 queued
    dp_auto = 1'b1;
    res_ready = 1'b0;
    instr_valid = 1'b1;
    instr = mk(5'd1);
    tick();
    instr = mk(5'd2);
    tick();
    instr = mk(5'd3);
    tick();
    instr = mk(5'd4);
    tick();
    chk("t4_ready3", 32'(instr_ready), 32'd1);
    instr = mk(5'd5);
    tick();
    instr_valid = 1'b0;
    chk("t4_full", 32'(instr_ready), 32'd0);
    chk("t4_rv", 32'(res_valid), 32'd1);
    chk("t4_data0", res_data, mk(5'd1) ^ 32'hCAFE0000);
    repeat (3) tick();
    chk("t4_hold_data", res_data, mk(5'd1) ^ 32'hCAFE0000);
    chk("t4_hold_rd", 32'(res_rd), 32'd1);
    chk("t4_hold_rv", 32'(res_valid), 32'd1);
    chk("t4_hold_ret", 32'(retired), 32'd2);
    res_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk("t4_seq_rv", 32'(res_valid), 32'd1);
      chk("t4_seq_rd", 32'(res_rd), 32'(k));
      chk("t4_seq_data", res_data,
          mk(5'(k)) ^ 32'hCAFE0000);
      tick();
      if (k == 1) chk("t4_reopen", 32'(instr_ready), 32'd1);
      repeat (3) tick();
    end
    chk("t4_ret", 32'(retired), 32'd7);
    chk("t4_busy", 32'(busy), 32'd0);

    // counter wrap
    for (int i = 0; i < 8; i++) begin
      run_one(mk(5'd6), got, gdata, grd);
      chk("t5_got", 32'(got), 32'd1);
    end
    chk("t5_max", 32'(retired), 32'd15);
    run_one(mk(5'd7), got, gdata, grd);
    chk("t5_wrap", 32'(retired), 32'd0);
    chk("t5_data", gdata, mk(5'd7) ^ 32'hCAFE0000);

    // reset during WRITE with one entry still queued
    instr = mk(5'd4);
    instr_valid = 1'b1;
    tick();
    instr = mk(5'd5);
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("t6_wr_we", 32'(dp_wr_en), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_we", 32'(dp_wr_en), 32'd0);
    chk("t6_rv", 32'(res_valid), 32'd0);
    chk("t6_ill", 32'(illegal), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ready", 32'(instr_ready), 32'd1);
    chk("t6_data", res_data, 32'd0);
    chk("t6_rd", 32'(res_rd), 32'd0);
    chk("t6_dpi", dp_instruction, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    run_one(mk(5'd9), got, gdata, grd);
    chk("t6_got", 32'(got), 32'd1);
    chk("t6_res", gdata, mk(5'd9) ^ 32'hCAFE0000);
    chk("t6_resrd", 32'(grd), 32'd9);
    chk("t6_ret", 32'(retired), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
